servo_instr_dispatcher: RTL and testbench
=========================================

SERVO_INSTR_DISPATCHER -- requirements
Module: servo_instr_dispatcher

Interface
REQ-001 Parameter REARM_CYCLES, 4, number of cycles rx_reset is held high to re-arm the serial instruction receiver (legal 2..15).
REQ-002 Parameter POS_MIN, 8'd16, lower position clamp bound (used only with POS_CLAMP_EN).
REQ-003 Parameter POS_MAX, 8'd240, upper position clamp bound (used only with POS_CLAMP_EN); POS_MIN <= POS_MAX.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 instruction_ready  input  1  receiver flag; high while a complete 10-bit instruction is held.
REQ-007 instruction  input  10  received word; [9:8] channel select, [7:0] position.
REQ-008 rx_reset  output  1  drives the receiver's reset; high re-arms it for the next word.
REQ-009 servo_wr  output  1  one-cycle strobe marking a position register update.
REQ-010 servo_sel  output  2  channel written on the servo_wr cycle.
REQ-011 pos_ch0, pos_ch1, pos_ch2, pos_ch3  output  8 each  current position register per servo channel.
REQ-012 instr_count  output  8  number of instructions dispatched, wraps 255 -> 0.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be REARM, WAIT_CLEAR, IDLE, CAPTURE, DISPATCH, with a registered state encoding.
REQ-015 REARM: rx_reset=1; internal counter counts REARM_CYCLES cycles, then -> WAIT_CLEAR.
REQ-016 WAIT_CLEAR: rx_reset=0; stay while instruction_ready=1; -> IDLE on first cycle instruction_ready=0.
REQ-017 IDLE: rx_reset=0; -> CAPTURE on the cycle instruction_ready=1 is sampled.
REQ-018 CAPTURE: instruction latched into internal instr_q at the end of this cycle; -> DISPATCH unconditionally.
REQ-019 DISPATCH: servo_wr=1, servo_sel=instr_q[9:8]; pos_ch[instr_q[9:8]] <= position value (REQ-029/030); instr_count <= instr_count+1 (mod 256); -> REARM.
REQ-020 Latency: ready sampled high in IDLE at cycle N -> servo_wr high in cycle N+2 -> rx_reset high cycles N+3..N+2+REARM_CYCLES.
REQ-021 Only the addressed pos_chX SHALL change on a dispatch; other channels hold.
REQ-022 servo_wr SHALL be high in exactly one cycle per accepted instruction and low otherwise; servo_sel holds its last value when servo_wr=0.
REQ-023 instruction_ready deasserting during CAPTURE SHALL NOT abort the dispatch; the latched instr_q is used.
REQ-024 instruction changes after CAPTURE SHALL have no effect on the dispatched value.
REQ-025 A receiver that never drops instruction_ready SHALL hold the block in WAIT_CLEAR indefinitely with busy=1 and no servo_wr.
REQ-026 busy SHALL be combinationally derived from state (0 only in IDLE).

Reset
REQ-027 While reset=1: state=REARM, rearm counter=0, rx_reset=1, servo_wr=0, servo_sel=0, pos_ch0..3=8'd128, instr_count=0, instr_q=0, busy=1.
REQ-028 After reset deasserts, a full REARM (REARM_CYCLES cycles) SHALL occur before IDLE; reset asserted mid-operation (any state) SHALL abandon the instruction with no register write.

Configuration
REQ-029 With POS_CLAMP_EN defined: written value = POS_MIN if instr_q[7:0] < POS_MIN, POS_MAX if > POS_MAX, else instr_q[7:0].
REQ-030 Without POS_CLAMP_EN: written value = instr_q[7:0] unmodified; POS_MIN/POS_MAX unused.

Verification
REQ-031 Reset release, REARM_CYCLES=4, ready=0 -> rx_reset high exactly 4 cycles post-release, then IDLE, busy=0, all pos_ch=128.
REQ-032 instruction=10'b10_0110_0100 with ready pulse -> servo_wr one cycle 2 cycles later, servo_sel=2, pos_ch2=100, others 128, instr_count=1.
REQ-033 With POS_CLAMP_EN: instruction=10'h005 -> pos_ch0=16; instruction=10'h1FA -> pos_ch1=240; without macro -> 5 and 250.
REQ-034 ready held high 20 cycles after a dispatch -> exactly one servo_wr, FSM stays WAIT_CLEAR until ready=0, then IDLE next cycle.
REQ-035 reset asserted during CAPTURE of instruction=10'h3FF -> pos_ch3 stays 128, instr_count=0, rx_reset high immediately.
REQ-036 256 back-to-back instructions -> instr_count wraps to 0, final pos registers match last write per channel.

Source files
------------

// File: rtl/servo_instr_dispatcher.sv
// Servo instruction dispatcher: captures a 10-bit word from the serial receiver, writes one channel position, then re-arms the receiver. POS_CLAMP_EN enables clamping to POS_MIN..POS_MAX.
// Latency: ready sampled in IDLE at cycle N -> servo_wr at N+2 -> rx_reset high N+3..N+2+REARM_CYCLES.
// Backpressure: none; a receiver that keeps instruction_ready high parks the block in WAIT_CLEAR.
module servo_instr_dispatcher #(
   parameter int unsigned REARM_CYCLES = 4,
   parameter logic [7:0]  POS_MIN      = 8'd16,
   parameter logic [7:0]  POS_MAX      = 8'd240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       instruction_ready,
   input  logic [9:0] instruction,
   output logic       rx_reset,
   output logic       servo_wr,
   output logic [1:0] servo_sel,
   output logic [7:0] pos_ch0,
   output logic [7:0] pos_ch1,
   output logic [7:0] pos_ch2,
   output logic [7:0] pos_ch3,
   output logic [7:0] instr_count,
   output logic       busy
);

   typedef enum logic [2:0] {
      REARM      = 3'd0,
      WAIT_CLEAR = 3'd1,
      IDLE       = 3'd2,
      CAPTURE    = 3'd3,
      DISPATCH   = 3'd4
   } state_t;

   localparam logic [3:0] REARM_LAST = 4'(REARM_CYCLES - 1);

   if (REARM_CYCLES < 2 || REARM_CYCLES > 15 || POS_MIN > POS_MAX) begin : g_bad_param
      $error("servo_instr_dispatcher: illegal REARM_CYCLES or POS_MIN > POS_MAX");
   end

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [9:0]      instr_q, instr_d;
   logic [1:0]      sel_q, sel_d;
   logic [3:0][7:0] pos_q, pos_d;
   logic [7:0]      count_q, count_d;
   logic [7:0]      wr_val;

   always_comb begin
      wr_val = instr_q[7:0];
`ifdef POS_CLAMP_EN
      if (instr_q[7:0] < POS_MIN) begin
         wr_val = POS_MIN;
      end else if (instr_q[7:0] > POS_MAX) begin
         wr_val = POS_MAX;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      sel_d   = sel_q;
      pos_d   = pos_q;
      count_d = count_q;
      case (state_q)
         REARM: begin
            if (cnt_q == REARM_LAST) begin
               cnt_d   = 4'd0;
               state_d = WAIT_CLEAR;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WAIT_CLEAR: begin
            if (!instruction_ready) state_d = IDLE;
         end
         IDLE: begin
            if (instruction_ready) state_d = CAPTURE;
         end
         CAPTURE: begin
            instr_d = instruction;
            state_d = DISPATCH;
         end
         DISPATCH: begin
            sel_d               = instr_q[9:8];
            pos_d[instr_q[9:8]] = wr_val;
            count_d             = count_q + 8'd1;
            cnt_d               = 4'd0;
            state_d             = REARM;
         end
         default: begin
            state_d = REARM;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= REARM;
         cnt_q   <= 4'd0;
         instr_q <= 10'd0;
         sel_q   <= 2'd0;
         pos_q   <= {4{8'd128}};
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         sel_q   <= sel_d;
         pos_q   <= pos_d;
         count_q <= count_d;
      end
   end

   // servo_sel shows the live channel during the strobe and the last written one otherwise
   assign rx_reset    = (state_q == REARM);
   assign servo_wr    = (state_q == DISPATCH);
   assign servo_sel   = servo_wr ? instr_q[9:8] : sel_q;
   assign busy        = (state_q != IDLE);
   assign pos_ch0     = pos_q[0];
   assign pos_ch1     = pos_q[1];
   assign pos_ch2     = pos_q[2];
   assign pos_ch3     = pos_q[3];
   assign instr_count = count_q;

endmodule

// File: tb/tb_servo_instr_dispatcher.sv
// Scoreboard bench for servo_instr_dispatcher: randomized instructions against a channel/position model.
module tb_servo_instr_dispatcher;

   localparam int REARM = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       instruction_ready = 1'b0;
   logic [9:0] instruction = 10'd0;
   logic       rx_reset, servo_wr, busy;
   logic [1:0] servo_sel;
   logic [7:0] pos_ch0, pos_ch1, pos_ch2, pos_ch3, instr_count;

   servo_instr_dispatcher #(.REARM_CYCLES(REARM), .POS_MIN(8'd16), .POS_MAX(8'd240)) dut (
      .clk(clk), .reset(reset), .instruction_ready(instruction_ready), .instruction(instruction),
      .rx_reset(rx_reset), .servo_wr(servo_wr), .servo_sel(servo_sel),
      .pos_ch0(pos_ch0), .pos_ch1(pos_ch1), .pos_ch2(pos_ch2), .pos_ch3(pos_ch3),
      .instr_count(instr_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]      sel;
      logic [3:0][7:0] pos;
      logic [7:0]      cnt;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         sent = 0;
   int         wr_seen = 0;
   int         m_pos[4];
   int         m_cnt;
   bit         pend = 0;
   exp_t       pend_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int expv(input int v);
`ifdef POS_CLAMP_EN
      if (v < 16) return 16;
      if (v > 240) return 240;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_pos[i] = 128;
      m_cnt = 0;
   endtask

   function automatic logic [31:0] dut_pos_all();
      return {pos_ch3, pos_ch2, pos_ch1, pos_ch0};
   endfunction

   // Monitor: the strobe cycle checks the channel, the following cycle checks the registers.
   always @(negedge clk) begin
      if (pend) begin
         chk("pos_regs", dut_pos_all(), pend_exp.pos);
         chk("instr_count", {24'd0, instr_count}, {24'd0, pend_exp.cnt});
         pend = 0;
      end
      if (servo_wr) begin
         wr_seen++;
         if (sb_q.size() == 0) begin
            chk("unexpected_servo_wr", 32'd1, 32'd0);
         end else begin
            pend_exp = sb_q.pop_front();
            chk("servo_sel", {30'd0, servo_sel}, {30'd0, pend_exp.sel});
            pend = 1;
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic send(input logic [9:0] w, input int hold);
      exp_t e;
      wait_idle();
      instruction       = w;
      instruction_ready = 1'b1;
      m_pos[w[9:8]] = expv(int'(w[7:0]));
      m_cnt = (m_cnt + 1) % 256;
      e.sel = w[9:8];
      for (int i = 0; i < 4; i++) e.pos[i] = 8'(m_pos[i]);
      e.cnt = 8'(m_cnt);
      sb_q.push_back(e);
      sent++;
      @(negedge clk);
      chk("capture_no_wr", {31'd0, servo_wr}, 32'd0);
      if (hold == 0) instruction_ready = 1'b0;
      @(negedge clk);
      chk("latency_wr", {31'd0, servo_wr}, 32'd1);
      instruction = 10'($urandom);
      for (int i = 0; i < REARM; i++) begin
         @(negedge clk);
         chk("rearm_high", {31'd0, rx_reset}, 32'd1);
      end
      @(negedge clk);
      chk("rearm_end", {31'd0, rx_reset}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         chk("wait_clear_busy", {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      instruction_ready = 1'b0;
      @(negedge clk);
      chk("back_to_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_rx_reset", {31'd0, rx_reset}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_servo_wr", {31'd0, servo_wr}, 32'd0);
      chk("rst_servo_sel", {30'd0, servo_sel}, 32'd0);
      chk("rst_pos", dut_pos_all(), 32'h80808080);
      chk("rst_count", {24'd0, instr_count}, 32'd0);
      reset = 1'b0;
      #1;
      n = 0;
      while (rx_reset && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("rearm_len_after_reset", n, REARM);
      chk("wait_clear_after_reset", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("idle_after_reset", {31'd0, busy}, 32'd0);
      chk("pos_after_reset", dut_pos_all(), 32'h80808080);

      send(10'b10_0110_0100, 0);
      chk("ch2_eq_100", {24'd0, pos_ch2}, 32'd100);
      send(10'h005, 0);
      send(10'h1FA, 0);
      send(10'($urandom), 20);
      for (int i = 0; i < 20; i++) send(10'($urandom), int'($urandom_range(0, 3)));

      // reset during CAPTURE abandons the word
      wait_idle();
      instruction       = 10'h3FF;
      instruction_ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      instruction_ready = 1'b0;
      #1;
      chk("abort_rx_reset", {31'd0, rx_reset}, 32'd1);
      chk("abort_no_wr", {31'd0, servo_wr}, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_ch3", {24'd0, pos_ch3}, 32'd128);
      chk("abort_count", {24'd0, instr_count}, 32'd0);

      for (int i = 0; i < 256; i++) send(10'($urandom), 0);
      chk("count_wrap", {24'd0, instr_count}, 32'd0);
      chk("final_pos", dut_pos_all(), {8'(m_pos[3]), 8'(m_pos[2]), 8'(m_pos[1]), 8'(m_pos[0])});

      repeat (3) @(negedge clk);
      chk("sb_empty", sb_q.size(), 32'd0);
      chk("one_wr_per_instr", wr_seen, sent);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
